// File: rtl/dac_pkg.sv
// Shared types for the DAC PWM output path.
//   DAC_W       : default sample / PWM counter width
//   dac_state_t : play-control state of the PWM renderer
package dac_pkg;

  localparam int DAC_W = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } dac_state_t;

endpackage

// File: rtl/dac_prescaler.sv
// PWM tick prescaler: divides clk down to one tick every PRESCALE cycles.
// Ports:
//   clk  : system clock
//   nRst : asynchronous active-low reset
//   run  : count enable; the counter is cleared while low
//   tick : high for one clk on the last cycle of each prescale interval
module dac_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic nRst,
  input  logic run,
  output logic tick
);

  localparam int            PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] r_presc;
  logic          w_last;

  assign w_last = (r_presc == LAST);
  assign tick   = run && w_last;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_presc <= '0;
    end else if (!run || w_last) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

endmodule

// File: rtl/dac_pwm_out.sv
// DAC sample sink: takes N-bit samples over valid/ready into a one-deep
// pending buffer and renders the active duty value as a PWM waveform.
// The duty value only changes on a PWM period boundary (or on start).
// Ports:
//   clk, nRst     : system clock, asynchronous active-low reset
//   en            : play enable
//   sample        : unsigned duty value, accepted when sample_valid && sample_ready
//   sample_valid  : producer presents a sample
//   sample_ready  : pending buffer empty
//   pwm_out       : registered PWM output
//   period_tick   : one-cycle pulse per completed PWM period
//   underrun      : one-cycle pulse when a period ended with nothing pending
//
// state | meaning
// IDLE  | counters held at zero, output low
// RUN   | rendering PWM periods
// STOP  | finishing the current period, then back to IDLE
module dac_pwm_out
  import dac_pkg::*;
#(
  parameter int N        = DAC_W,
  parameter int PRESCALE = 4
) (
  input  logic         clk,
  input  logic         nRst,
  input  logic         en,
  input  logic [N-1:0] sample,
  input  logic         sample_valid,
  output logic         sample_ready,
  output logic         pwm_out,
  output logic         period_tick,
  output logic         underrun
);

  localparam logic [N-1:0] CNT_LAST = '1;

  dac_state_t   r_state, w_state_nxt;
  logic [N-1:0] r_pwm_cnt;
  logic [N-1:0] r_duty;
  logic [N-1:0] r_pending;
  logic         r_pending_full;
  logic         r_pwm_out;
  logic         r_period_tick;
  logic         r_underrun;

  logic w_run, w_tick, w_period_end, w_accept, w_start, w_consume;

  assign w_run        = (r_state != IDLE);
  assign w_period_end = w_tick && (r_pwm_cnt == CNT_LAST);
  assign w_accept     = sample_valid && !r_pending_full;
  assign w_start      = (r_state == IDLE) && en;
  // accept and consume never coincide: accept needs an empty buffer
  assign w_consume    = (w_start || w_period_end) && r_pending_full;

  dac_prescaler #(.PRESCALE(PRESCALE)) u_presc (
    .clk  (clk),
    .nRst (nRst),
    .run  (w_run),
    .tick (w_tick)
  );

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (en) w_state_nxt = RUN;
      RUN:     if (!en) w_state_nxt = STOP;
      STOP: begin
        // re-enabling keeps the running phase; otherwise let the period finish
        if (en)                w_state_nxt = RUN;
        else if (w_period_end) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_pwm_cnt <= '0;
    end else if (!w_run) begin
      r_pwm_cnt <= '0;
    end else if (w_tick) begin
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_duty         <= '0;
      r_pending      <= '0;
      r_pending_full <= 1'b0;
    end else begin
      if (w_start) begin
        r_duty <= r_pending_full ? r_pending : '0;
      end else if (w_period_end && r_pending_full) begin
        r_duty <= r_pending;
      end
      if (w_accept) begin
        r_pending      <= sample;
        r_pending_full <= 1'b1;
      end else if (w_consume) begin
        r_pending_full <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_pwm_out     <= 1'b0;
      r_period_tick <= 1'b0;
      r_underrun    <= 1'b0;
    end else begin
      r_pwm_out     <= w_run && (r_pwm_cnt < r_duty);
      r_period_tick <= w_period_end;
      r_underrun    <= w_period_end && !r_pending_full;
    end
  end

  assign sample_ready = !r_pending_full;
  assign pwm_out      = r_pwm_out;
  assign period_tick  = r_period_tick;
  assign underrun     = r_underrun;

endmodule

// File: tb/tb_dac_pwm_out.sv
module tb_dac_pwm_out;

  localparam int N      = 3;
  localparam int P      = 2;
  localparam int PERIOD = (1 << N) * P;

  logic         clk = 1'b0;
  logic         nRst = 1'b0;
  logic         en = 1'b0;
  logic [N-1:0] sample = '0;
  logic         sample_valid = 1'b0;
  logic         sample_ready, pwm_out, period_tick, underrun;

  dac_pwm_out #(.N(N), .PRESCALE(P)) dut (
    .clk          (clk),
    .nRst         (nRst),
    .en           (en),
    .sample       (sample),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .pwm_out      (pwm_out),
    .period_tick  (period_tick),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // Reference model: one phase counter in clk cycles over the whole period.
  int m_mode;   // 0 stopped, 1 playing, 2 finishing last period
  int m_p;      // clk-cycle phase within the period
  int m_duty, m_pend;
  bit m_full, m_pwm, m_tick, m_under;

  typedef struct {
    int smp;
    int exp_high;
  } vec_t;
  vec_t vecs[4];

  task automatic chk(input string name, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
  endtask

  function automatic void m_reset();
    m_mode = 0; m_p = 0; m_duty = 0; m_pend = 0;
    m_full = 0; m_pwm = 0; m_tick = 0; m_under = 0;
  endfunction

  function automatic void m_update();
    bit active, pend_end, acc;
    active   = (m_mode != 0);
    pend_end = active && (m_p == PERIOD - 1);
    acc      = sample_valid && !m_full;
    m_pwm    = active && ((m_p / P) < m_duty);
    m_tick   = pend_end;
    m_under  = pend_end && !m_full;
    if (!active && en) begin
      m_duty = m_full ? m_pend : 0;
      m_full = 0;
    end else if (pend_end && m_full) begin
      m_duty = m_pend;
      m_full = 0;
    end
    if (acc) begin
      m_pend = int'(sample);
      m_full = 1;
    end
    m_p = active ? (m_p + 1) % PERIOD : 0;
    case (m_mode)
      0:       if (en) m_mode = 1;
      1:       if (!en) m_mode = 2;
      default: if (en) m_mode = 1; else if (pend_end) m_mode = 0;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    if (!nRst) m_reset();
    else m_update();
    #1;
    chk("model_pwm_out", int'(pwm_out), int'(m_pwm));
    chk("model_period_tick", int'(period_tick), int'(m_tick));
    chk("model_underrun", int'(underrun), int'(m_under));
    chk("model_sample_ready", int'(sample_ready), int'(!m_full));
  endtask

  task automatic push(input int v);
    sample = N'(v);
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
  endtask

  task automatic wait_tick(output int steps, output int hi);
    steps = 0;
    hi = 0;
    do begin
      step();
      steps++;
      hi += int'(pwm_out);
    end while (!period_tick && steps < 40);
    chk("tick_wait", int'(period_tick), 1);
  endtask

  task automatic run_steps(input int n, output int hi, output int nt, output int nu);
    hi = 0; nt = 0; nu = 0;
    for (int i = 0; i < n; i++) begin
      step();
      hi += int'(pwm_out);
      nt += int'(period_tick);
      nu += int'(underrun);
    end
  endtask

  initial begin
    int hi, nt, nu, n, h, acc_done;
    bit pre;

    vecs[0] = '{smp: 0, exp_high: 0};
    vecs[1] = '{smp: 7, exp_high: 14};
    vecs[2] = '{smp: 1, exp_high: 2};
    vecs[3] = '{smp: 5, exp_high: 10};

    m_reset();
    #3;
    chk("reset_pwm_out", int'(pwm_out), 0);
    chk("reset_period_tick", int'(period_tick), 0);
    chk("reset_underrun", int'(underrun), 0);
    chk("reset_sample_ready", int'(sample_ready), 1);
    step();
    step();
    #2 nRst = 1'b1;

    // idle with en low
    run_steps(40, hi, nt, nu);
    chk("idle_high", hi, 0);
    chk("idle_ticks", nt, 0);
    chk("idle_ready", int'(sample_ready), 1);

    // start with duty 3
    push(3);
    chk("pending_ready_low", int'(sample_ready), 0);
    en = 1'b1;
    step();
    run_steps(PERIOD, hi, nt, nu);
    chk("start_high", hi, 6);
    chk("start_period_tick", int'(period_tick), 1);
    chk("start_underrun", int'(underrun), 1);

    // starved: duty holds, underrun every period
    run_steps(2 * PERIOD, hi, nt, nu);
    chk("starve_high", hi, 12);
    chk("starve_ticks", nt, 2);
    chk("starve_underruns", nu, 2);

    // one sample per period at assorted duties
    for (int i = 0; i < 4; i++) begin
      push(vecs[i].smp);
      wait_tick(n, h);
      run_steps(PERIOD, hi, nt, nu);
      chk($sformatf("vec%0d_high", i), hi, vecs[i].exp_high);
      chk($sformatf("vec%0d_tick", i), int'(period_tick), 1);
      chk($sformatf("vec%0d_underrun", i), int'(underrun), 1);
    end

    // back-to-back 5 then 7
    push(5);
    chk("b2b_ready_low", int'(sample_ready), 0);
    sample = 3'd7;
    sample_valid = 1'b1;
    acc_done = 0;
    for (int i = 0; i < 40 && acc_done == 0; i++) begin
      pre = sample_ready;
      step();
      if (pre) acc_done = 1;
    end
    sample_valid = 1'b0;
    chk("b2b_accept7", acc_done, 1);
    hi = int'(pwm_out);
    wait_tick(n, h);
    chk("b2b_period5_len", n + 1, PERIOD);
    chk("b2b_period5_high", hi + h, 10);
    run_steps(PERIOD, hi, nt, nu);
    chk("b2b_period7_high", hi, 14);

    // drop en mid-period: period completes, then idle
    run_steps(5, hi, nt, nu);
    en = 1'b0;
    wait_tick(n, h);
    chk("stop_remaining", n, PERIOD - 5);
    chk("stop_period_high", hi + h, 14);
    run_steps(20, hi, nt, nu);
    chk("stopped_high", hi, 0);
    chk("stopped_ticks", nt, 0);

    // re-raise en while stopping: phase continues
    push(3);
    en = 1'b1;
    step();
    wait_tick(n, h);
    chk("restart_len", n, PERIOD);
    run_steps(4, hi, nt, nu);
    en = 1'b0;
    run_steps(3, h, nt, nu);
    hi += h;
    en = 1'b1;
    wait_tick(n, h);
    chk("reraise_len", n + 7, PERIOD);
    chk("reraise_high", hi + h, 6);

    // async reset mid-period with pending full
    push(7);
    wait_tick(n, h);
    run_steps(2, hi, nt, nu);
    push(5);
    chk("prerst_pwm_out", int'(pwm_out), 1);
    chk("prerst_ready", int'(sample_ready), 0);
    #2 nRst = 1'b0;
    #1;
    chk("arst_pwm_out", int'(pwm_out), 0);
    chk("arst_period_tick", int'(period_tick), 0);
    chk("arst_underrun", int'(underrun), 0);
    chk("arst_ready", int'(sample_ready), 1);
    m_reset();
    en = 1'b0;
    step();
    step();
    #2 nRst = 1'b1;
    run_steps(10, hi, nt, nu);
    chk("post_rst_ready", int'(sample_ready), 1);
    chk("post_rst_high", hi, 0);

    // randomized traffic against the model
    en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) en = ~en;
      sample_valid = ($urandom_range(0, 3) == 0);
      sample = N'($urandom_range(0, (1 << N) - 1));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
